// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/reset_source_filter.sv
// One reset source: 2-flop synchroniser followed by a saturating low-counter.
// The flag asserts only after FILTER_CYCLES consecutive synchronised low
// samples; any high sample clears the counter, so release is not filtered.
module reset_source_filter
  import reset_seq_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic resetn_source,
  output logic flag_c
);

  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] primed_q;
  logic [CNT_W-1:0]      cnt_q;

  // Synchroniser plus a primed marker: the synchroniser resets to 0, which
  // would otherwise look like a low request right after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_DEPTH-2:0], resetn_source};
      primed_q <= {primed_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  // Saturating count of consecutive low synchronised samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!primed_q[SYNC_DEPTH-1] || sync_q[SYNC_DEPTH-1]) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign flag_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Global reset generator: filtered, maskable reset sources plus an optional
// software request trigger a hold period followed by a staggered release of
// the domain resets; the sticky cause register records what triggered it.
// Build option: RESET_SEQ_SW_REQ_EN enables the software reset request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned SOURCES_WIDTH      = 4,
  parameter int unsigned OUTPUTS_COUNT      = 3,
  parameter int unsigned HOLD_COUNTER_WIDTH = 16,
  parameter int unsigned STAGE_DELAY_WIDTH  = 8,
  parameter int unsigned FILTER_CYCLES      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SOURCES_WIDTH-1:0] resetn_sources,
  input  logic [SOURCES_WIDTH-1:0] source_mask,
  input  logic                     sw_reset_req,
  input  logic                     cause_clear,
  output logic [OUTPUTS_COUNT-1:0] resetn_out,
  output logic                     reset_active,
  output logic [SOURCES_WIDTH:0]   reset_cause
);

  localparam int unsigned STAGE_W = (OUTPUTS_COUNT > 1) ? $clog2(OUTPUTS_COUNT) : 1;
  localparam logic [HOLD_COUNTER_WIDTH-1:0] HOLD_MAX  = '1;
  localparam logic [STAGE_DELAY_WIDTH-1:0]  DELAY_MAX = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(OUTPUTS_COUNT - 1);

  seq_state_t                    state_q, state_nxt;
  logic [HOLD_COUNTER_WIDTH-1:0] hold_cnt_q, hold_cnt_nxt;
  logic [STAGE_W-1:0]            stage_q, stage_nxt;
  logic [STAGE_DELAY_WIDTH-1:0]  stage_cnt_q, stage_cnt_nxt;
  logic [OUTPUTS_COUNT-1:0]      resetn_nxt;
  logic                          active_nxt;
  logic [SOURCES_WIDTH:0]        cause_nxt;
  logic [SOURCES_WIDTH-1:0]      flags;
  logic                          sw_bit;
  logic [SOURCES_WIDTH:0]        trig_bits_c;
  logic                          trigger_c;

  for (genvar i = 0; i < SOURCES_WIDTH; i++) begin : g_src
    reset_source_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
      .clk          (clk),
      .reset        (reset),
      .resetn_source(resetn_sources[i]),
      .flag_c       (flags[i])
    );
  end

`ifdef RESET_SEQ_SW_REQ_EN
  assign sw_bit = sw_reset_req;
`else
  logic unused_sw_reset_req;
  assign unused_sw_reset_req = sw_reset_req;
  assign sw_bit = 1'b0;
`endif

  assign trig_bits_c = {sw_bit, flags & ~source_mask};
  assign trigger_c   = |trig_bits_c;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HOLD;
    else       state_q <= state_nxt;
  end

  // Next-state logic; a trigger outside ASSERT always restarts the sequence.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ASSERT: state_nxt = HOLD;
      HOLD: begin
        if (trigger_c)                    state_nxt = ASSERT;
        else if (hold_cnt_q == HOLD_MAX)  state_nxt = (OUTPUTS_COUNT == 1) ? RUN : RELEASE;
      end
      RELEASE: begin
        if (trigger_c) state_nxt = ASSERT;
        else if (stage_cnt_q == DELAY_MAX &&
                 STAGE_W'(stage_q + STAGE_W'(1)) == STAGE_LAST) state_nxt = RUN;
      end
      RUN: if (trigger_c) state_nxt = ASSERT;
      default: state_nxt = HOLD;
    endcase
  end

  // Counter, output and cause next values derived from the transition.
  always_comb begin
    hold_cnt_nxt  = '0;
    stage_nxt     = '0;
    stage_cnt_nxt = '0;
    resetn_nxt    = '0;
    cause_nxt     = cause_clear ? '0 : reset_cause;

    if (state_q == HOLD && state_nxt == HOLD && hold_cnt_q != HOLD_MAX)
      hold_cnt_nxt = hold_cnt_q + HOLD_COUNTER_WIDTH'(1);
    else if (state_q == HOLD && state_nxt == HOLD)
      hold_cnt_nxt = hold_cnt_q;

    if (state_q == RELEASE && state_nxt == RELEASE) begin
      if (stage_cnt_q == DELAY_MAX) begin
        stage_nxt     = stage_q + STAGE_W'(1);
        stage_cnt_nxt = '0;
      end else begin
        stage_nxt     = stage_q;
        stage_cnt_nxt = stage_cnt_q + STAGE_DELAY_WIDTH'(1);
      end
    end

    for (int unsigned k = 0; k < OUTPUTS_COUNT; k++)
      resetn_nxt[k] = (state_nxt == RUN) ||
                      ((state_nxt == RELEASE) && (k <= 32'(stage_nxt)));

    active_nxt = (state_nxt != RUN);

    if (state_nxt == ASSERT) cause_nxt = cause_nxt | trig_bits_c;
  end

  // Registered counters and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q   <= '0;
      stage_q      <= '0;
      stage_cnt_q  <= '0;
      resetn_out   <= '0;
      reset_active <= 1'b1;
      reset_cause  <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_nxt;
      stage_q      <= stage_nxt;
      stage_cnt_q  <= stage_cnt_nxt;
      resetn_out   <= resetn_nxt;
      reset_active <= active_nxt;
      reset_cause  <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with a time-based reference model.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int SW  = 2;
  localparam int OC  = 3;
  localparam int HW  = 4;
  localparam int SDW = 2;
  localparam int FC  = 2;
  localparam int HOLD_T  = 1 << HW;
  localparam int STAGE_T = 1 << SDW;
`ifdef RESET_SEQ_SW_REQ_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] resetn_sources;
  logic [SW-1:0] source_mask;
  logic          sw_reset_req;
  logic          cause_clear;
  logic [OC-1:0] resetn_out;
  logic          reset_active;
  logic [SW:0]   reset_cause;

  int n_cmp = 0;
  int n_err = 0;

  reset_sequencer #(
    .SOURCES_WIDTH(SW), .OUTPUTS_COUNT(OC), .HOLD_COUNTER_WIDTH(HW),
    .STAGE_DELAY_WIDTH(SDW), .FILTER_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .resetn_sources(resetn_sources),
    .source_mask(source_mask), .sw_reset_req(sw_reset_req),
    .cause_clear(cause_clear), .resetn_out(resetn_out),
    .reset_active(reset_active), .reset_cause(reset_cause)
  );

  always #5 clk = ~clk;

  // Reference model: low-run length per raw sample (newest first), time since
  // the last hold start, and the sticky cause.
  int          run_q [SW][3];
  bit          m_in_assert;
  int          m_t;
  logic [SW:0] m_cause;
  int          m_hold_entry;
  int          cyc;

  always @(posedge clk or posedge reset) begin
    logic [SW:0] bits;
    if (reset) begin
      for (int i = 0; i < SW; i++) for (int j = 0; j < 3; j++) run_q[i][j] = 0;
      m_in_assert = 0; m_t = 0; m_cause = '0; m_hold_entry = 0; cyc = 0;
    end else begin
      cyc = cyc + 1;
      bits = '0;
      // A request seen low on FC consecutive raw samples is acted on three
      // edges after the last of them (2 sync stages + counter register).
      for (int i = 0; i < SW; i++) bits[i] = (run_q[i][2] >= FC) && !source_mask[i];
      bits[SW] = SW_EN && sw_reset_req;
      for (int i = 0; i < SW; i++) begin
        run_q[i][2] = run_q[i][1];
        run_q[i][1] = run_q[i][0];
        run_q[i][0] = resetn_sources[i] ? 0 : ((run_q[i][0] >= FC) ? FC : run_q[i][0] + 1);
      end
      if (cause_clear) m_cause = '0;
      if ((|bits) && !m_in_assert) begin
        m_in_assert = 1;
        m_cause = m_cause | bits;
      end else if (m_in_assert) begin
        m_in_assert = 0; m_t = 0; m_hold_entry = cyc;
      end else if (m_t < 1000000) begin
        m_t = m_t + 1;
      end
    end
  end

  function automatic logic [OC-1:0] exp_out();
    int k;
    if (m_in_assert || m_t < HOLD_T) return '0;
    k = (m_t - HOLD_T) / STAGE_T + 1;
    if (k > OC) k = OC;
    return OC'((1 << k) - 1);
  endfunction

  function automatic logic exp_active();
    return exp_out() != {OC{1'b1}};
  endfunction

  task automatic test_reset();
    logic [OC-1:0] want;
    reset = 1'b1; resetn_sources = '1; source_mask = '0;
    sw_reset_req = 1'b0; cause_clear = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (resetn_out !== 3'b000) begin n_err++; $display("FAIL reset_out: got %b expected 000", resetn_out); end
    n_cmp++; if (reset_active !== 1'b1) begin n_err++; $display("FAIL reset_active: got %b expected 1", reset_active); end
    n_cmp++; if (reset_cause !== 3'b000) begin n_err++; $display("FAIL reset_cause: got %b expected 000", reset_cause); end
    reset = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      n_cmp++; if (resetn_out !== exp_out()) begin n_err++; $display("FAIL poweron_out e%0d: got %b expected %b", e, resetn_out, exp_out()); end
      n_cmp++; if (reset_active !== exp_active()) begin n_err++; $display("FAIL poweron_active e%0d: got %b expected %b", e, reset_active, exp_active()); end
      n_cmp++; if (reset_cause !== 3'b000) begin n_err++; $display("FAIL poweron_cause e%0d: got %b expected 000", e, reset_cause); end
      if (e == 15 || e == 16 || e == 20 || e == 24) begin
        want = (e == 15) ? 3'b000 : (e == 16) ? 3'b001 : (e == 20) ? 3'b011 : 3'b111;
        n_cmp++; if (resetn_out !== want) begin n_err++; $display("FAIL poweron_edge%0d: got %b expected %b", e, resetn_out, want); end
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk); resetn_sources[0] = 1'b0;
    @(negedge clk); resetn_sources[0] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      n_cmp++; if (resetn_out !== 3'b111) begin n_err++; $display("FAIL glitch_out: got %b expected 111", resetn_out); end
      n_cmp++; if (reset_cause !== m_cause) begin n_err++; $display("FAIL glitch_cause: got %b expected %b", reset_cause, m_cause); end
    end
  endtask

  task automatic test_source_assert();
    @(negedge clk); resetn_sources[0] = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      @(negedge clk);
      if (e == 3) begin
        resetn_sources[0] = 1'b1;
        n_cmp++; if (resetn_out !== 3'b111) begin n_err++; $display("FAIL src_edge3_out: got %b expected 111", resetn_out); end
      end
      if (e == 4) begin
        n_cmp++; if (resetn_out !== 3'b000) begin n_err++; $display("FAIL src_edge4_out: got %b expected 000", resetn_out); end
        n_cmp++; if (reset_cause !== 3'b001) begin n_err++; $display("FAIL src_edge4_cause: got %b expected 001", reset_cause); end
      end
    end
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      n_cmp++; if (resetn_out !== exp_out()) begin n_err++; $display("FAIL src_seq_out: got %b expected %b", resetn_out, exp_out()); end
      n_cmp++; if (reset_active !== exp_active()) begin n_err++; $display("FAIL src_seq_active: got %b expected %b", reset_active, exp_active()); end
    end
  endtask

  task automatic test_mask();
    @(negedge clk); source_mask = 2'b10; resetn_sources[1] = 1'b0;
    for (int e = 0; e < 100; e++) begin
      @(negedge clk);
      n_cmp++; if (resetn_out !== 3'b111) begin n_err++; $display("FAIL mask_out: got %b expected 111", resetn_out); end
      n_cmp++; if (reset_cause !== 3'b001) begin n_err++; $display("FAIL mask_cause: got %b expected 001", reset_cause); end
    end
    resetn_sources[1] = 1'b1;
    repeat (6) @(negedge clk);
    source_mask = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++; if (resetn_out !== 3'b111) begin n_err++; $display("FAIL unmask_out: got %b expected 111", resetn_out); end
  endtask

  task automatic test_sw_mid_release();
    int  waited;
    logic [OC-1:0] want;
    @(negedge clk); cause_clear = 1'b1;
    @(negedge clk); cause_clear = 1'b0;
    n_cmp++; if (reset_cause !== 3'b000) begin n_err++; $display("FAIL clear_cause: got %b expected 000", reset_cause); end
    resetn_sources[0] = 1'b0;
    repeat (4) @(negedge clk);
    resetn_sources[0] = 1'b1;
    waited = 0;
    while (resetn_out !== 3'b011 && waited < 80) begin @(negedge clk); waited++; end
    n_cmp++; if (resetn_out !== 3'b011) begin n_err++; $display("FAIL sw_wait011: got %b expected 011", resetn_out); end
    sw_reset_req = 1'b1;
    @(negedge clk); sw_reset_req = 1'b0;
    want = SW_EN ? 3'b000 : 3'b011;
    n_cmp++; if (resetn_out !== want) begin n_err++; $display("FAIL sw_out: got %b expected %b", resetn_out, want); end
    n_cmp++; if (reset_cause[SW] !== SW_EN) begin n_err++; $display("FAIL sw_cause_msb: got %b expected %b", reset_cause[SW], SW_EN); end
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      n_cmp++; if (resetn_out !== exp_out()) begin n_err++; $display("FAIL sw_seq_out: got %b expected %b", resetn_out, exp_out()); end
      n_cmp++; if (reset_cause !== m_cause) begin n_err++; $display("FAIL sw_seq_cause: got %b expected %b", reset_cause, m_cause); end
    end
  endtask

  task automatic test_hold_retrigger();
    int waited;
    int s;
    int rise;
    resetn_sources[0] = 1'b0;
    repeat (4) @(negedge clk);
    resetn_sources[0] = 1'b1;
    waited = 0;
    while (!(m_t == 10 && !m_in_assert) && waited < 40) begin @(negedge clk); waited++; end
    n_cmp++; if (resetn_out !== 3'b000) begin n_err++; $display("FAIL hold10_out: got %b expected 000", resetn_out); end
    s = cyc + 1;
    resetn_sources[0] = 1'b0;
    repeat (3) @(negedge clk);
    resetn_sources[0] = 1'b1;
    rise = -1;
    for (int e = 0; e < 60 && rise < 0; e++) begin
      @(negedge clk);
      n_cmp++; if (resetn_out !== exp_out()) begin n_err++; $display("FAIL retrig_out: got %b expected %b", resetn_out, exp_out()); end
      if (resetn_out[0] === 1'b1) rise = cyc;
    end
    n_cmp++; if (rise - s !== 21) begin n_err++; $display("FAIL retrig_rise: got %0d expected 21", rise - s); end
    n_cmp++; if (rise - m_hold_entry !== HOLD_T) begin n_err++; $display("FAIL retrig_hold: got %0d expected %0d", rise - m_hold_entry, HOLD_T); end
  endtask

  task automatic test_cause_clear();
    int waited;
    logic [SW:0] want;
    waited = 0;
    while (resetn_out !== 3'b111 && waited < 60) begin @(negedge clk); waited++; end
    n_cmp++; if (resetn_out !== 3'b111) begin n_err++; $display("FAIL cc_wait_run: got %b expected 111", resetn_out); end
    cause_clear = 1'b1;
    @(negedge clk); cause_clear = 1'b0;
    n_cmp++; if (reset_cause !== 3'b000) begin n_err++; $display("FAIL cc_clear: got %b expected 000", reset_cause); end
    resetn_sources[0] = 1'b0;
    repeat (4) @(negedge clk);
    resetn_sources[0] = 1'b1;
    @(negedge clk);
    n_cmp++; if (reset_cause !== 3'b001) begin n_err++; $display("FAIL cc_src: got %b expected 001", reset_cause); end
    repeat (3) @(negedge clk);
    sw_reset_req = 1'b1; cause_clear = 1'b1;
    @(negedge clk); sw_reset_req = 1'b0; cause_clear = 1'b0;
    want = SW_EN ? 3'b100 : 3'b000;
    n_cmp++; if (reset_cause !== want) begin n_err++; $display("FAIL cc_same_cycle: got %b expected %b", reset_cause, want); end
    repeat (30) @(negedge clk);
    n_cmp++; if (resetn_out !== exp_out()) begin n_err++; $display("FAIL cc_after_out: got %b expected %b", resetn_out, exp_out()); end
  endtask

  task automatic test_random();
    int burst [SW];
    for (int i = 0; i < SW; i++) burst[i] = 0;
    for (int e = 0; e < 3000; e++) begin
      @(negedge clk);
      n_cmp++; if (resetn_out !== exp_out()) begin n_err++; $display("FAIL rand_out c%0d: got %b expected %b", cyc, resetn_out, exp_out()); end
      n_cmp++; if (reset_active !== exp_active()) begin n_err++; $display("FAIL rand_active c%0d: got %b expected %b", cyc, reset_active, exp_active()); end
      n_cmp++; if (reset_cause !== m_cause) begin n_err++; $display("FAIL rand_cause c%0d: got %b expected %b", cyc, reset_cause, m_cause); end
      for (int i = 0; i < SW; i++) begin
        if (burst[i] > 0) burst[i]--;
        else if ($urandom_range(0, 59) == 0) burst[i] = $urandom_range(1, 6);
        resetn_sources[i] = (burst[i] == 0);
      end
      sw_reset_req = ($urandom_range(0, 199) == 0);
      cause_clear  = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) source_mask = SW'($urandom_range(0, 3));
    end
    resetn_sources = '1; sw_reset_req = 1'b0; cause_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_source_assert();
    test_mask();
    test_sw_mid_release();
    test_hold_retrigger();
    test_cause_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised global reset generator that replaces the single-source, single-output reset stretcher in the multiprocessor designs. It accepts up to SOURCES_WIDTH asynchronous active-low reset requests plus a software request. Each source is synchronised, glitch-filtered and maskable. After a programmable hold time, the block releases OUTPUTS_COUNT active-low reset domains in a fixed, staggered order, and it records which source caused the last reset. It sits at the top level between board reset pins and the Qsys system and bridge reset inputs.

## Interface
- SOURCES_WIDTH, 4, number of external active-low reset sources
- OUTPUTS_COUNT, 3, number of sequenced reset domains; bit 0 is released first
- HOLD_COUNTER_WIDTH, 16, hold time = 2^HOLD_COUNTER_WIDTH cycles with all sources quiet
- STAGE_DELAY_WIDTH, 8, gap between consecutive domain releases = 2^STAGE_DELAY_WIDTH cycles
- FILTER_CYCLES, 4, consecutive synchronised-low samples needed to accept a source (≥1)
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- resetn_sources  in  SOURCES_WIDTH  asynchronous active-low reset requests
- source_mask  in  SOURCES_WIDTH  1 = source ignored (quasi-static)
- sw_reset_req  in  1  synchronous single-cycle software reset request
- cause_clear  in  1  synchronous pulse that clears reset_cause
- resetn_out  out  OUTPUTS_COUNT  registered active-low domain resets
- reset_active  out  1  high whenever any domain is held in reset
- reset_cause  out  SOURCES_WIDTH+1  sticky cause; bit i = source i, MSB = software

## Operation
- Each source passes through a 2-flop synchroniser and then a saturating low-counter. The filtered flag is high while the counter equals FILTER_CYCLES. The counter clears on any high sample, so release is unfiltered.
- trigger = OR over i of (flag[i] & ~source_mask[i]), OR sw_reset_req.
- The FSM has four states: ASSERT, HOLD, RELEASE, RUN.
  - ASSERT: lasts one cycle. All resetn_out are 0. Goes to HOLD with the hold counter at 0.
  - HOLD: the hold counter increments each cycle. A trigger returns the FSM to ASSERT. When the counter reaches 2^HOLD_COUNTER_WIDTH−1, the FSM goes to RELEASE with stage index 0.
  - RELEASE: sets resetn_out[stage] on entry, then every 2^STAGE_DELAY_WIDTH cycles advances the stage and sets the next bit. Set bits stay set. After setting bit OUTPUTS_COUNT−1, the FSM goes to RUN.
  - RUN: all resetn_out are 1.
- A trigger in HOLD, RELEASE or RUN causes ASSERT on the next edge, which forces all resetn_out to 0.
- reset_active = (state != RUN).
- reset_cause: on the edge that enters ASSERT, OR in the triggering bits; existing bits are kept.
  - cause_clear zeroes the register.
  - If cause_clear and a new trigger occur in the same cycle, set wins for the new bits.
- Reset values (reset high): state=HOLD, hold counter=0, all resetn_out=0, reset_active=1, reset_cause=0, synchronisers=0, filter counters=0.
- Power-on therefore yields a full hold and sequenced release. reset_cause stays 0.

## Timing
- External source: first edge sampling it low is edge 0. The flag is high after edge 1+FILTER_CYCLES. All resetn_out are 0 after edge 2+FILTER_CYCLES.
- sw_reset_req sampled high at edge 0 gives all resetn_out=0 after edge 0.
- Release timing, measured from the last HOLD entry edge:
  - resetn_out[0]=1 after 2^HOLD_COUNTER_WIDTH edges.
  - resetn_out[k] rises k·2^STAGE_DELAY_WIDTH edges later.
- Counters never wrap. The hold counter stops at terminal count, and the stage counter clears on stage advance.
- Changing source_mask mid-filter only affects trigger gating. Filter counters keep running.

## Configuration
- RESET_SEQ_SW_REQ_EN
  - Defined: sw_reset_req participates in trigger and reset_cause MSB.
  - Undefined: sw_reset_req is ignored and the reset_cause MSB is constant 0. Port list is unchanged.

## Structure
- Shared package reset_seq_pkg holds the FSM state enum (ASSERT, HOLD, RELEASE, RUN) and the synchroniser depth constant (2).
- One sub-module, reset_source_filter: synchroniser plus low-counter for one source, instantiated SOURCES_WIDTH times with a generate loop.

## Test plan
Parameters: SOURCES_WIDTH=2, OUTPUTS_COUNT=3, HOLD_COUNTER_WIDTH=4, STAGE_DELAY_WIDTH=2, FILTER_CYCLES=2; macro defined.
- Power-on: reset high 3 cycles then low, sources high.
  - resetn_out 000 → 001 at edge 16 → 011 at edge 20 → 111 at edge 24.
  - reset_active falls with 111. reset_cause=000.
- In RUN, pulse source0 low for 1 cycle → no change.
  - Then hold it low for 4 cycles → resetn_out=000 after edge 4 (edge 0 = first low sample), reset_cause=001.
- With source_mask=10, hold source1 low for 100 cycles in RUN → resetn_out stays 111 and reset_cause is unchanged.
- sw_reset_req at edge 0 while resetn_out=011 → resetn_out=000 after edge 0, reset_cause MSB=1, full re-sequence follows.
- In HOLD at hold count 10, source0 low for 3 cycles → FSM re-enters ASSERT; resetn_out[0] rises exactly 16 edges after the final HOLD entry.
- cause_clear in the same cycle as an sw_reset_req-driven ASSERT with reset_cause=001 → reset_cause=100.
